// File: rtl/meio_subtrator_trio.sv
// Registered 1-bit half subtractor built three ways (gate, dataflow, truth table) with a cross-check.
// Latency 1 cycle; no backpressure, a sample is accepted every cycle.
module meio_subtrator_trio #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             A,
    input  logic             B,
    output logic             out_valid,
    output logic             D_1,
    output logic             Borrow_1,
    output logic             D_2,
    output logic             Borrow_2,
    output logic             D_3,
    output logic             Borrow_3,
    output logic             mismatch,
    output logic             error_sticky,
    output logic [CNT_W-1:0] borrow_cnt
);

    // Implementation 1: primitive gates.
    wire d_1_c;
    wire borrow_1_c;
    wire a_n;

    xor g_xor (d_1_c, A, B);
    not g_not (a_n, A);
    and g_and (borrow_1_c, a_n, B);

    // Implementation 2: dataflow.
    logic d_2_c;
    logic borrow_2_c;

    assign d_2_c      = A ^ B;
    assign borrow_2_c = ~A & B;

    // Implementation 3: truth table. The result is routed through a net so a
    // hierarchical force on it is cleanly undone by release.
    logic d_3_tt;
    logic borrow_3_tt;
    logic d_3_c;
    logic borrow_3_c;

    always_comb begin
        d_3_tt      = 1'b0;
        borrow_3_tt = 1'b0;
        case ({A, B})
            2'b00:   begin d_3_tt = 1'b0; borrow_3_tt = 1'b0; end
            2'b01:   begin d_3_tt = 1'b1; borrow_3_tt = 1'b1; end
            2'b10:   begin d_3_tt = 1'b1; borrow_3_tt = 1'b0; end
            2'b11:   begin d_3_tt = 1'b0; borrow_3_tt = 1'b0; end
            default: begin d_3_tt = 1'b0; borrow_3_tt = 1'b0; end
        endcase
    end

    assign d_3_c      = d_3_tt;
    assign borrow_3_c = borrow_3_tt;

    logic mismatch_c;
    assign mismatch_c = (d_1_c != d_2_c) | (d_1_c != d_3_c)
                      | (borrow_1_c != borrow_2_c) | (borrow_1_c != borrow_3_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            D_1          <= 1'b0;
            Borrow_1     <= 1'b0;
            D_2          <= 1'b0;
            Borrow_2     <= 1'b0;
            D_3          <= 1'b0;
            Borrow_3     <= 1'b0;
            mismatch     <= 1'b0;
            error_sticky <= 1'b0;
            borrow_cnt   <= '0;
        end else begin
            out_valid <= in_valid;
            D_1       <= d_1_c;
            Borrow_1  <= borrow_1_c;
            D_2       <= d_2_c;
            Borrow_2  <= borrow_2_c;
            D_3       <= d_3_c;
            Borrow_3  <= borrow_3_c;
            mismatch  <= mismatch_c;
            if (in_valid && mismatch_c)
                error_sticky <= 1'b1;
            // Saturate at all-ones rather than wrap.
            if (in_valid && borrow_2_c && (borrow_cnt != {CNT_W{1'b1}}))
                borrow_cnt <= borrow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_meio_subtrator_trio.sv
// Bench for meio_subtrator_trio: directed plan steps plus random samples against an arithmetic model.
module tb_meio_subtrator_trio;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       A;
    logic       B;
    logic       out_valid;
    logic       D_1, Borrow_1, D_2, Borrow_2, D_3, Borrow_3;
    logic       mismatch;
    logic       error_sticky;
    logic [7:0] borrow_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_cnt;
    logic m_valid;
    logic m_d;
    logic m_b;
    logic m_sticky;

    always #5 clk = ~clk;

    meio_subtrator_trio #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(out_valid),
        .D_1(D_1), .Borrow_1(Borrow_1),
        .D_2(D_2), .Borrow_2(Borrow_2),
        .D_3(D_3), .Borrow_3(Borrow_3),
        .mismatch(mismatch), .error_sticky(error_sticky),
        .borrow_cnt(borrow_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one cycle of inputs, advances the model and compares every output.
    task automatic step(input logic a, input logic b, input logic v, input logic r, input string tag);
        int diff;
        @(negedge clk);
        A = a; B = b; in_valid = v; rst = r;
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_valid = 0; m_d = 0; m_b = 0; m_sticky = 0;
        end else begin
            diff    = int'(a) - int'(b);
            m_d     = (diff != 0);
            m_b     = (diff < 0);
            m_valid = v;
            if (v && m_b && m_cnt < 255) m_cnt = m_cnt + 1;
        end
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".pairs"}, 32'({D_1, Borrow_1, D_2, Borrow_2, D_3, Borrow_3}),
              32'({m_d, m_b, m_d, m_b, m_d, m_b}));
        check({tag, ".mismatch"}, 32'(mismatch), 32'(0));
        check({tag, ".sticky"}, 32'(error_sticky), 32'(m_sticky));
        check({tag, ".borrow_cnt"}, 32'(borrow_cnt), 32'(m_cnt));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = 1'b0; B = 1'b0;
        m_cnt = 0; m_valid = 0; m_d = 0; m_b = 0; m_sticky = 0;

        step(1'b1, 1'b1, 1'b1, 1'b1, "reset0");
        step(1'b0, 1'b1, 1'b1, 1'b1, "reset1");

        step(1'b0, 1'b0, 1'b1, 1'b0, "a0b0");
        step(1'b1, 1'b0, 1'b1, 1'b0, "seq_10");
        step(1'b1, 1'b1, 1'b1, 1'b0, "seq_11");
        step(1'b0, 1'b1, 1'b1, 1'b0, "seq_01");
        check("seq_cnt_one", 32'(borrow_cnt), 32'd1);

        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1, 1'b0, "sat");
        check("sat_cnt_255", 32'(borrow_cnt), 32'd255);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "idle");
        check("idle_cnt_held", 32'(borrow_cnt), 32'd255);

        // Forced disagreement on the truth-table borrow.
        @(negedge clk);
        A = 1'b1; B = 1'b1; in_valid = 1'b1; rst = 1'b0;
        force dut.borrow_3_c = 1'b1;
        @(posedge clk);
        #1;
        check("force.mismatch", 32'(mismatch), 32'd1);
        check("force.sticky", 32'(error_sticky), 32'd1);
        check("force.borrow_3", 32'(Borrow_3), 32'd1);
        check("force.borrow_1", 32'(Borrow_1), 32'd0);
        release dut.borrow_3_c;
        m_sticky = 1'b1; m_d = 1'b0; m_b = 1'b0; m_valid = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0, "post_release");
        step(1'b1, 1'b1, 1'b1, 1'b0, "post_release2");

        // Mid-stream reset with a valid borrowing sample presented.
        step(1'b0, 1'b1, 1'b1, 1'b1, "mid_rst");
        step(1'b0, 1'b1, 1'b1, 1'b0, "first_after_rst");
        check("first_after_rst_cnt", 32'(borrow_cnt), 32'd1);

        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/meio_subtrator_trio.md
Name: meio_subtrator_trio

Overview:
- Registered 1-bit half subtractor (minuend A, subtrahend B) computed by three independent internal implementations in parallel: gate-level, dataflow and behavioural truth table.
- Each implementation's difference and borrow is presented on its own registered output pair.
- A cross-check flags any disagreement between the implementations.
- A saturating counter tallies accepted samples that produce a borrow.
- Used as a self-checking arithmetic primitive in bit-serial subtract datapaths.

Parameters:
- CNT_W, 8, width of the borrow-event counter (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies A/B for this cycle.
- A  input  1  minuend.
- B  input  1  subtrahend.
- out_valid  output  1  registered copy of in_valid.
- D_1  output  1  difference, gate-level implementation.
- Borrow_1  output  1  borrow, gate-level implementation.
- D_2  output  1  difference, dataflow implementation.
- Borrow_2  output  1  borrow, dataflow implementation.
- D_3  output  1  difference, behavioural truth-table implementation.
- Borrow_3  output  1  borrow, behavioural truth-table implementation.
- mismatch  output  1  this result's three pairs disagree.
- error_sticky  output  1  set once any mismatch occurred; cleared only by rst.
- borrow_cnt  output  CNT_W  saturating count of accepted samples with Borrow=1.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst) and has priority over all other updates.
- Arithmetic, identical for all three implementations:
  - D = A XOR B.
  - Borrow = (NOT A) AND B.
  - Truth table (A,B -> D,Borrow): 00->0,0; 01->1,1; 10->1,0; 11->0,0.
- Implementation 1: primitive gate instances only (xor, not, and).
- Implementation 2: continuous assignments only.
- Implementation 3: combinational always block with a case on {A,B}. Default branch drives 0,0; it is reached on X/Z inputs in simulation.
- Latency: exactly 1 cycle. Results for A/B sampled at edge n appear after edge n.
- Output register update:
  - D_x/Borrow_x update every cycle regardless of in_valid.
  - out_valid follows in_valid with one cycle delay.
- mismatch: registered. Set to 1 when the three (D,Borrow) pairs are not all equal, evaluated on the same inputs as the registered results. Evaluated every cycle.
- error_sticky:
  - Set on any cycle where mismatch is being registered as 1 and in_valid was 1.
  - Holds until rst.
- borrow_cnt:
  - Increments by 1 on each edge where in_valid=1 and the implementation-2 borrow is 1.
  - Saturates at all-ones and never wraps.
  - in_valid=0 leaves it unchanged.
- Reset values: out_valid=0, all D_x=0, all Borrow_x=0, mismatch=0, error_sticky=0, borrow_cnt=0.
- Reset asserted mid-stream:
  - Inputs presented in the rst cycle are discarded.
  - The first result after rst deassertion is for the first post-reset input.
- Reset asserted with in_valid=1: counter and sticky remain 0.
- Back-to-back valid samples are accepted every cycle with no stall.
- In a correct design mismatch and error_sticky never assert. The verifier forces disagreement through hierarchical force on one internal implementation net.

Test Plan:
- Reset then A=0,B=0,in_valid=1 -> next cycle all D_x=0, Borrow_x=0, out_valid=1, mismatch=0, borrow_cnt=0.
- Sequence A/B = 1/0, 1/1, 0/1, one per cycle, in_valid=1:
  - Outputs one cycle later are D=1,0,1 and Borrow=0,0,1 on all three pairs.
  - borrow_cnt ends at 1.
- Hold A=0,B=1,in_valid=1 for 300 cycles with CNT_W=8 -> borrow_cnt reaches 255 and stays 255.
- A=0,B=1 with in_valid=0 for 5 cycles -> D_x=1, Borrow_x=1, out_valid=0, borrow_cnt unchanged.
- Force implementation-3 borrow to 1 while A=1,B=1,in_valid=1:
  - Next cycle mismatch=1 and error_sticky=1.
  - After release, mismatch returns to 0 and error_sticky stays 1 until rst.
- Assert rst for one cycle mid-sequence with in_valid=1 -> next cycle all outputs are 0, including borrow_cnt and error_sticky.
